sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_bit_cnt.sv | 38 +++
 rtl/sipo_deser.sv | 102 ++++++++++
 tb/tb_sipo_deser.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out deserializer.
//   state_e       : FSM encoding (IDLE = no bits held, SHIFT = partial word held)
//   DEFAULT_WIDTH : default parallel word width
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sipo_bit_cnt.sv
// Bit counter for the deserializer: tracks how many bits of the current
// partial word have been accepted.
//   clk   : clock, rising edge
//   inc_i : count one accepted bit
//   clr_i : restart the word; if inc_i is also high the current bit is
//           counted as the first bit of the new word
//   cnt_o : bits held in the partial word
//   tc_o  : terminal count, the next accepted bit completes the word
module sipo_bit_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CW'(1) : '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserializer with frame-alignment strobe.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in        : serial data bit, sampled when in_valid=1
//   in_valid  : qualifies in
//   sync      : discards any partial word (current bit starts a new word
//               if in_valid is also high)
//   out       : last completed parallel word (registered, held)
//   out_valid : one-cycle pulse marking a new word on out
//   bit_cnt   : number of bits held in the current partial word
//
// state | meaning
// IDLE  | no bits of a word held (bit_cnt = 0)
// SHIFT | partial word held (0 < bit_cnt < WIDTH)
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       sync,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] base, shifted;
  logic             tc, done, cnt_inc, cnt_clr;

  // sync overrides word completion, so a synced bit never finishes a word.
  assign done    = in_valid & ~sync & (state_q == SHIFT) & tc;
  assign cnt_clr = rst | sync | done;
  assign cnt_inc = in_valid & ~done & ~rst;

  sipo_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk   (clk),
    .inc_i (cnt_inc),
    .clr_i (cnt_clr),
    .cnt_o (bit_cnt),
    .tc_o  (tc)
  );

  always_comb begin
    base = sync ? '0 : sr_q;
    if (MSB_FIRST != 0) begin
      shifted = {base[WIDTH-2:0], in};
    end else begin
      shifted = {in, base[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (in_valid && sync) state_d = SHIFT;
        else if (sync)        state_d = IDLE;
        else if (done)        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (in_valid) begin
      sr_d = done ? '0 : shifted;
    end else if (sync) begin
      sr_d = '0;
    end
    if (done) out_d = shifted;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      out_q       <= out_d;
      out_valid_q <= done;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

  logic       clk;
  logic       rst;
  logic       din;
  logic       in_valid;
  logic       sync;
  logic [3:0] out_m, out_l;
  logic       ov_m, ov_l;
  logic [2:0] bc_m, bc_l;

  int n_cmp;
  int n_err;

  logic [3:0] q_m[$];
  logic [3:0] q_l[$];
  logic [3:0] last_m, last_l;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .sync(sync),
    .out(out_m), .out_valid(ov_m), .bit_cnt(bc_m)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .sync(sync),
    .out(out_l), .out_valid(ov_l), .bit_cnt(bc_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected words in arrival order: seq[3] is the first bit sent.
  task automatic push(input logic [3:0] seq);
    logic [3:0] rev;
    for (int i = 0; i < 4; i++) rev[i] = seq[3-i];
    q_m.push_back(seq);
    q_l.push_back(rev);
    last_m = seq;
    last_l = rev;
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the
  // edge, and any completed word is checked against the scoreboard.
  task automatic cyc(input logic v, input logic b, input logic s);
    logic [3:0] exp;
    in_valid = v;
    din      = b;
    sync     = s;
    @(posedge clk);
    #1;
    if (ov_m === 1'b1) begin
      n_cmp++;
      if (q_m.size() == 0) begin
        n_err++;
        $display("FAIL sb_msb: unexpected word %b, none expected", out_m);
      end else begin
        exp = q_m.pop_front();
        if (out_m !== exp) begin
          n_err++;
          $display("FAIL sb_msb: got %b, expected %b", out_m, exp);
        end
      end
    end
    if (ov_l === 1'b1) begin
      n_cmp++;
      if (q_l.size() == 0) begin
        n_err++;
        $display("FAIL sb_lsb: unexpected word %b, none expected", out_l);
      end else begin
        exp = q_l.pop_front();
        if (out_l !== exp) begin
          n_err++;
          $display("FAIL sb_lsb: got %b, expected %b", out_l, exp);
        end
      end
    end
  endtask

  task automatic send_word(input logic [3:0] seq);
    push(seq);
    for (int i = 3; i >= 0; i--) cyc(1'b1, seq[i], 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (out_m !== 4'b0 || out_l !== 4'b0) begin
      n_err++;
      $display("FAIL reset_out: got %b/%b, expected 0000/0000", out_m, out_l);
    end
    n_cmp++;
    if (ov_m !== 1'b0 || ov_l !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ov: got %b/%b, expected 0/0", ov_m, ov_l);
    end
    n_cmp++;
    if (bc_m !== 3'd0 || bc_l !== 3'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d/%0d, expected 0/0", bc_m, bc_l);
    end
    rst = 1'b0;
    last_m = 4'b0;
    last_l = 4'b0;
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    send_word(4'b1100);
    n_cmp++;
    if (ov_m !== 1'b1 || ov_l !== 1'b1) begin
      n_err++;
      $display("FAIL basic_pulse: got %b/%b, expected 1/1", ov_m, ov_l);
    end
    n_cmp++;
    if (out_m !== 4'b1100 || out_l !== 4'b0011) begin
      n_err++;
      $display("FAIL basic_word: got %b/%b, expected 1100/0011", out_m, out_l);
    end
    cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ov_m !== 1'b0 || ov_l !== 1'b0 || bc_m !== 3'd0) begin
      n_err++;
      $display("FAIL basic_one_cycle: got ov %b/%b cnt %0d, expected 0/0 cnt 0", ov_m, ov_l, bc_m);
    end
    n_cmp++;
    if (out_m !== 4'b1100 || out_l !== 4'b0011) begin
      n_err++;
      $display("FAIL basic_hold: got %b/%b, expected 1100/0011", out_m, out_l);
    end
  endtask

  task automatic test_gap();
    push(4'b1001);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (bc_m !== 3'd2 || bc_l !== 3'd2 || ov_m !== 1'b0) begin
        n_err++;
        $display("FAIL gap_hold: cycle %0d cnt %0d/%0d ov %b, expected 2/2 ov 0", i, bc_m, bc_l, ov_m);
      end
    end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (ov_m !== 1'b1 || out_m !== 4'b1001) begin
      n_err++;
      $display("FAIL gap_word: got ov %b out %b, expected ov 1 out 1001", ov_m, out_m);
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    bits = 8'b1001_1101;
    push(4'b1001);
    push(4'b1101);
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b1, bits[i], 1'b0);
      if (i == 4 || i == 0) begin
        n_cmp++;
        if (ov_m !== 1'b1 || ov_l !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_pulse: edge %0d ov %b/%b, expected 1/1", 8 - i, ov_m, ov_l);
        end
      end else if (i == 3) begin
        n_cmp++;
        if (ov_m !== 1'b0 || bc_m !== 3'd1 || bc_l !== 3'd1) begin
          n_err++;
          $display("FAIL b2b_next: ov %b cnt %0d/%0d, expected ov 0 cnt 1/1", ov_m, bc_m, bc_l);
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sync_mid();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (bc_m !== 3'd1 || bc_l !== 3'd1 || ov_m !== 1'b0) begin
      n_err++;
      $display("FAIL sync_mid_cnt: cnt %0d/%0d ov %b, expected 1/1 ov 0", bc_m, bc_l, ov_m);
    end
    n_cmp++;
    if (out_m !== last_m || out_l !== last_l) begin
      n_err++;
      $display("FAIL sync_mid_hold: got %b/%b, expected %b/%b", out_m, out_l, last_m, last_l);
    end
    push(4'b1010);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sync_alone();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (bc_m !== 3'd0 || bc_l !== 3'd0 || ov_m !== 1'b0 || out_m !== last_m) begin
      n_err++;
      $display("FAIL sync_alone: cnt %0d/%0d ov %b out %b, expected 0/0 ov 0 out %b", bc_m, bc_l, ov_m, out_m, last_m);
    end
    send_word(4'b0111);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sync_at_complete();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (ov_m !== 1'b0 || ov_l !== 1'b0 || bc_m !== 3'd1 || bc_l !== 3'd1) begin
      n_err++;
      $display("FAIL sync_complete: ov %b/%b cnt %0d/%0d, expected 0/0 cnt 1/1", ov_m, ov_l, bc_m, bc_l);
    end
    n_cmp++;
    if (out_m !== last_m || out_l !== last_l) begin
      n_err++;
      $display("FAIL sync_complete_hold: got %b/%b, expected %b/%b", out_m, out_l, last_m, last_l);
    end
    push(4'b1001);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (out_m !== 4'b0 || out_l !== 4'b0 || bc_m !== 3'd0 || bc_l !== 3'd0 || ov_m !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: out %b/%b cnt %0d/%0d ov %b, expected 0000/0000 cnt 0/0 ov 0", out_m, out_l, bc_m, bc_l, ov_m);
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    send_word(4'b0110);
    n_cmp++;
    if (ov_m !== 1'b1 || out_m !== 4'b0110 || out_l !== 4'b0110) begin
      n_err++;
      $display("FAIL reset_mid_word: ov %b out %b/%b, expected ov 1 out 0110/0110", ov_m, out_m, out_l);
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    din      = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    last_m   = 4'b0;
    last_l   = 4'b0;

    test_reset();
    test_basic();
    test_gap();
    test_back_to_back();
    test_sync_mid();
    test_sync_alone();
    test_sync_at_complete();
    test_reset_mid();

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d/%0d words never produced, expected 0/0", q_m.size(), q_l.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
